// File: rtl/vending_machine_pkg.sv
// Shared definitions for the vending machine: state encodings, item codes,
// prices and coin values in cents, plus credit/state conversion helpers.
package vending_machine_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'b000,
      CR0  = 3'b001,
      CR5  = 3'b010,
      CR10 = 3'b011,
      CR15 = 3'b100,
      CR20 = 3'b101,
      RF5  = 3'b110,
      RF10 = 3'b111
   } state_t;

   localparam logic [1:0] ITEM_NONE = 2'b00;
   localparam logic [1:0] ITEM_15   = 2'b01;
   localparam logic [1:0] ITEM_20   = 2'b10;
   localparam logic [1:0] ITEM_25   = 2'b11;

   localparam logic [4:0] PRICE_15    = 5'd15;
   localparam logic [4:0] PRICE_20    = 5'd20;
   localparam logic [4:0] PRICE_25    = 5'd25;
   localparam logic [4:0] COIN_NICKEL = 5'd5;
   localparam logic [4:0] COIN_DIME   = 5'd10;

   // Credit held by a credit state; non-credit states hold nothing.
   function automatic logic [4:0] state_credit(input state_t s);
      case (s)
         CR5:     state_credit = 5'd5;
         CR10:    state_credit = 5'd10;
         CR15:    state_credit = 5'd15;
         CR20:    state_credit = 5'd20;
         default: state_credit = 5'd0;
      endcase
   endfunction

   // Credit state for a below-price credit amount.
   function automatic state_t credit_state(input logic [4:0] c);
      case (c)
         5'd0:    credit_state = CR0;
         5'd5:    credit_state = CR5;
         5'd10:   credit_state = CR10;
         5'd15:   credit_state = CR15;
         5'd20:   credit_state = CR20;
         default: credit_state = IDLE;
      endcase
   endfunction

endpackage

// File: rtl/vm_price_lookup.sv
// Maps the latched item code to its price in cents (no item -> 0).
module vm_price_lookup
   import vending_machine_pkg::*;
(
   input  logic [1:0] selected_item,
   output logic [4:0] price
);

   // Pure table lookup.
   always_comb begin
      price = 5'd0;
      case (selected_item)
         ITEM_15: price = PRICE_15;
         ITEM_20: price = PRICE_20;
         ITEM_25: price = PRICE_25;
         default: price = 5'd0;
      endcase
   end

endmodule

// File: rtl/vending_machine_mealy.sv
// Mealy vending machine: 15/20/25c items, nickel/dime coins, at most 5c
// overpayment returned with the vend. Cancel and the RF5/RF10 refund
// states are built only when VM_CANCEL_EN is defined; otherwise cancel is
// ignored and RF5/RF10 decode to IDLE. ps and selected_item are kept as
// plainly named registers so they can be probed hierarchically.
module vending_machine_mealy
   import vending_machine_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       nickel,
   input  logic       dime,
   input  logic       cancel,
   input  logic [1:0] item_select,
   output logic       vend,
   output logic       change_5C,
   output logic       change_10C
);

   state_t     ps;
   state_t     ns;
   logic [1:0] selected_item;
   logic [1:0] sel_next;
   logic [4:0] price;
   logic [4:0] credit;
   logic [4:0] credit_new;
   logic       cancel_req;
   logic       vend_c;
   logic       c5_c;
   logic       c10_c;

   vm_price_lookup u_price (
      .selected_item (selected_item),
      .price         (price)
   );

`ifdef VM_CANCEL_EN
   assign cancel_req = cancel;
`else
   logic unused_cancel;
   assign unused_cancel = cancel;
   assign cancel_req    = 1'b0;
`endif

   // Dime wins over nickel when both arrive in one cycle.
   assign credit     = state_credit(ps);
   assign credit_new = credit + (dime ? COIN_DIME : COIN_NICKEL);

   // State and selection registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ps            <= IDLE;
         selected_item <= ITEM_NONE;
      end else begin
         ps            <= ns;
         selected_item <= sel_next;
      end
   end

   // Next state, next selection and Mealy outputs.
   always_comb begin
      ns       = ps;
      sel_next = selected_item;
      vend_c   = 1'b0;
      c5_c     = 1'b0;
      c10_c    = 1'b0;
      case (ps)
         IDLE: begin
            if (item_select != ITEM_NONE) begin
               ns       = CR0;
               sel_next = item_select;
            end
         end
         CR0, CR5, CR10, CR15, CR20: begin
            if (cancel_req) begin
               // Refund credit; 15c and 20c need a second coin cycle.
               case (ps)
                  CR5:  begin c5_c  = 1'b1; ns = IDLE; end
                  CR10: begin c10_c = 1'b1; ns = IDLE; end
                  CR15: begin c10_c = 1'b1; ns = RF5;  end
                  CR20: begin c10_c = 1'b1; ns = RF10; end
                  default: ns = IDLE;
               endcase
            end else if (dime || nickel) begin
               if (credit_new < price) begin
                  ns = credit_state(credit_new);
               end else begin
                  // Overpayment is at most one nickel.
                  vend_c = 1'b1;
                  c5_c   = (credit_new != price);
                  ns     = IDLE;
               end
            end
         end
`ifdef VM_CANCEL_EN
         RF5:  begin c5_c  = 1'b1; ns = IDLE; end
         RF10: begin c10_c = 1'b1; ns = IDLE; end
`endif
         default: ns = IDLE;
      endcase
      if (ns == IDLE) sel_next = ITEM_NONE;
   end

   assign vend       = rst & vend_c;
   assign change_5C  = rst & c5_c;
   assign change_10C = rst & c10_c;

endmodule

// File: tb/tb_vending_machine_mealy.sv
// Directed bench for vending_machine_mealy. Each step drives one cycle of
// inputs, queues the expected outputs and next state/selection, then checks
// outputs mid-cycle and state just after the following rising edge.
// Expectations follow VM_CANCEL_EN when the bench is built with it.
module tb_vending_machine_mealy;
   import vending_machine_pkg::*;

`ifdef VM_CANCEL_EN
   localparam bit CANCEL_EN = 1'b1;
`else
   localparam bit CANCEL_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       nickel;
   logic       dime;
   logic       cancel;
   logic [1:0] item_select;
   logic       vend;
   logic       change_5C;
   logic       change_10C;

   logic [7:0] exp_q[$];
   int         n_cmp;
   int         n_fail;

   vending_machine_mealy dut (
      .clk         (clk),
      .rst         (rst),
      .nickel      (nickel),
      .dime        (dime),
      .cancel      (cancel),
      .item_select (item_select),
      .vend        (vend),
      .change_5C   (change_5C),
      .change_10C  (change_10C)
   );

   // Clock: 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle: drive at posedge+1, check outputs at negedge, state at posedge+1.
   task automatic step(input string tag, input logic n, input logic d,
                       input logic c, input logic [1:0] s,
                       input logic [2:0] e_out, input logic [2:0] e_ps,
                       input logic [1:0] e_sel);
      logic [7:0] e;
      logic [2:0] obs_out;
      logic [4:0] obs_st;
      nickel      = n;
      dime        = d;
      cancel      = c;
      item_select = s;
      exp_q.push_back({e_out, e_ps, e_sel});
      @(negedge clk);
      e       = exp_q.pop_front();
      obs_out = {vend, change_5C, change_10C};
      n_cmp++;
      assert (obs_out === e[7:5]) else begin
         n_fail++;
         $error("FAIL %s outputs {vend,c5,c10}: got %b expected %b", tag, obs_out, e[7:5]);
      end
      @(posedge clk);
      #1;
      obs_st = {dut.ps, dut.selected_item};
      n_cmp++;
      assert (obs_st === e[4:0]) else begin
         n_fail++;
         $error("FAIL %s state {ps,sel}: got %b expected %b", tag, obs_st, e[4:0]);
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_fail      = 0;
      rst         = 1'b0;
      nickel      = 1'b0;
      dime        = 1'b0;
      cancel      = 1'b0;
      item_select = 2'b00;
      @(posedge clk);
      #1;

      // Reset with selection and coins present: nothing happens.
      step("reset", 1, 1, 0, 2'b11, 3'b000, IDLE, 2'b00);
      rst = 1'b1;

      // Coins and cancel without a selection are ignored.
      step("idle_nickel", 1, 0, 0, 2'b00, 3'b000, IDLE, 2'b00);
      step("idle_dime",   0, 1, 0, 2'b00, 3'b000, IDLE, 2'b00);
      step("idle_cancel", 0, 0, 1, 2'b00, 3'b000, IDLE, 2'b00);

      // 15c: nickel + dime, exact.
      step("i15_sel",    0, 0, 0, 2'b01, 3'b000, CR0,  2'b01);
      step("i15_nickel", 1, 0, 0, 2'b00, 3'b000, CR5,  2'b01);
      step("i15_dime",   0, 1, 0, 2'b00, 3'b100, IDLE, 2'b00);

      // 25c: three dimes, 5c change with the vend.
      step("i25_sel",   0, 0, 0, 2'b11, 3'b000, CR0,  2'b11);
      step("i25_dime1", 0, 1, 0, 2'b00, 3'b000, CR10, 2'b11);
      step("i25_dime2", 0, 1, 0, 2'b00, 3'b000, CR20, 2'b11);
      step("i25_dime3", 0, 1, 0, 2'b00, 3'b110, IDLE, 2'b00);

      // Selection change mid-payment is ignored.
      step("lock_sel",    0, 0, 0, 2'b01, 3'b000, CR0,  2'b01);
      step("lock_nickel", 1, 0, 0, 2'b10, 3'b000, CR5,  2'b01);
      step("lock_dime",   0, 1, 0, 2'b10, 3'b100, IDLE, 2'b00);

      // 25c: dime, nickel, cancel -> 10c then 5c refund.
      step("rf5_sel",    0, 0, 0, 2'b11, 3'b000, CR0,  2'b11);
      step("rf5_dime",   0, 1, 0, 2'b00, 3'b000, CR10, 2'b11);
      step("rf5_nickel", 1, 0, 0, 2'b00, 3'b000, CR15, 2'b11);
      step("rf5_cancel", 0, 0, 1, 2'b00,
           CANCEL_EN ? 3'b001 : 3'b000, CANCEL_EN ? RF5 : CR15, 2'b11);
      step("rf5_next",   0, 1, 0, 2'b00,
           CANCEL_EN ? 3'b010 : 3'b100, IDLE, 2'b00);

      // 25c: two dimes, cancel -> 10c twice.
      step("rf10_sel",    0, 0, 0, 2'b11, 3'b000, CR0,  2'b11);
      step("rf10_dime1",  0, 1, 0, 2'b00, 3'b000, CR10, 2'b11);
      step("rf10_dime2",  0, 1, 0, 2'b00, 3'b000, CR20, 2'b11);
      step("rf10_cancel", 0, 0, 1, 2'b00,
           CANCEL_EN ? 3'b001 : 3'b000, CANCEL_EN ? RF10 : CR20, 2'b11);
      step("rf10_next",   1, 0, 0, 2'b00,
           CANCEL_EN ? 3'b001 : 3'b100, IDLE, 2'b00);

      // 20c: priority dime > nickel, then cancel > dime.
      step("pri_sel",    0, 0, 0, 2'b10, 3'b000, CR0,  2'b10);
      step("pri_both",   1, 1, 0, 2'b00, 3'b000, CR10, 2'b10);
      step("pri_cancel", 0, 1, 1, 2'b00,
           CANCEL_EN ? 3'b001 : 3'b100, IDLE, 2'b00);

      // 20c: four nickels, exact.
      step("n4_sel", 0, 0, 0, 2'b10, 3'b000, CR0,  2'b10);
      step("n4_c1",  1, 0, 0, 2'b00, 3'b000, CR5,  2'b10);
      step("n4_c2",  1, 0, 0, 2'b00, 3'b000, CR10, 2'b10);
      step("n4_c3",  1, 0, 0, 2'b00, 3'b000, CR15, 2'b10);
      step("n4_c4",  1, 0, 0, 2'b00, 3'b100, IDLE, 2'b00);

      // Selecting with a coin in IDLE ignores the coin; 15c then overpaid.
      step("ov_sel",   1, 0, 0, 2'b01, 3'b000, CR0,  2'b01);
      step("ov_dime1", 0, 1, 0, 2'b00, 3'b000, CR10, 2'b01);
      step("ov_dime2", 0, 1, 0, 2'b00, 3'b110, IDLE, 2'b00);

      // Reset mid-payment: outputs suppressed, no refund afterwards.
      step("mr_sel",   0, 0, 0, 2'b11, 3'b000, CR0,  2'b11);
      step("mr_dime1", 0, 1, 0, 2'b00, 3'b000, CR10, 2'b11);
      step("mr_dime2", 0, 1, 0, 2'b00, 3'b000, CR20, 2'b11);
      rst = 1'b0;
      step("mr_reset", 0, 1, 1, 2'b00, 3'b000, IDLE, 2'b00);
      rst = 1'b1;
      step("mr_after", 0, 0, 0, 2'b00, 3'b000, IDLE, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
